cmd_bus_pin_ctrl: RTL and testbench

- Responder on the external command bus driven by the scheduler. Decodes its address window and holds a small register file. Drives one digital pin as a static level or a programmable square wave, or samples the pin as an input and counts rising edges.
- Answers bus reads with one-cycle latency. One instance per physical pin.

---
 rtl/cmd_bus_pin_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cmd_bus_pin_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_bus_pin_ctrl.sv
// rtl/cmd_bus_pin_ctrl.sv - command-bus responder driving one pin as static level, square wave or edge-counting input
// Optional rising-edge counter in INPUT mode is built only when PIN_CTRL_EDGE_COUNT_EN is defined.
module cmd_bus_pin_ctrl #(
  parameter logic [18:0] BASE_ADDR   = 19'h00100,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] cmd_bus_addr,
  input  logic [15:0] cmd_bus_data,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_rd,
  input  logic        cmd_bus_wr,
  output logic [15:0] bus_rd_data,
  output logic        bus_rd_valid,
  input  logic        pin_in,
  output logic        pin_out,
  output logic        pin_oe
);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_HIZ    = 2'd2;
  localparam logic [1:0] MODE_INPUT  = 2'd3;

  localparam logic [3:0] REG_MODE       = 4'd0;
  localparam logic [3:0] REG_HIGH_TIME  = 4'd1;
  localparam logic [3:0] REG_LOW_TIME   = 4'd2;
  localparam logic [3:0] REG_STATIC_VAL = 4'd3;
  localparam logic [3:0] REG_EDGE_COUNT = 4'd4;
  localparam logic [3:0] REG_STATUS     = 4'd5;

  typedef enum logic {
    SQ_HIGH = 1'b0,
    SQ_LOW  = 1'b1
  } sq_state_t;

  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic [3:0]  reg_sel;

  logic [1:0]  mode;
  logic [15:0] high_time;
  logic [15:0] low_time;
  logic        static_val;

  sq_state_t   sq_state;
  sq_state_t   sq_state_nxt;
  logic [15:0] phase_cnt;
  logic [15:0] phase_cnt_nxt;
  logic [15:0] high_eff;
  logic [15:0] low_eff;
  logic [15:0] phase_limit;
  logic        sq_start;

  logic        sync_meta;
  logic        sync_q;
  logic [15:0] edge_rd;
  logic [15:0] rd_mux;

  assign hit     = cmd_bus_en && (cmd_bus_addr[18:4] == BASE_ADDR[18:4]);
  assign wr_hit  = hit && cmd_bus_wr;
  assign rd_hit  = hit && cmd_bus_rd && !cmd_bus_wr;
  assign reg_sel = cmd_bus_addr[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= MODE_STATIC;
      high_time  <= 16'd1;
      low_time   <= 16'd1;
      static_val <= RESET_LEVEL;
    end else if (wr_hit) begin
      case (reg_sel)
        REG_MODE:       mode       <= cmd_bus_data[1:0];
        REG_HIGH_TIME:  high_time  <= cmd_bus_data;
        REG_LOW_TIME:   low_time   <= cmd_bus_data;
        REG_STATIC_VAL: static_val <= cmd_bus_data[0];
        default: ;
      endcase
    end
  end

  // Any MODE write selecting SQUARE (re)starts the waveform at the high phase.
  assign sq_start = wr_hit && (reg_sel == REG_MODE) && (cmd_bus_data[1:0] == MODE_SQUARE);

  assign high_eff    = (high_time == 16'd0) ? 16'd1 : high_time;
  assign low_eff     = (low_time == 16'd0) ? 16'd1 : low_time;
  assign phase_limit = (sq_state == SQ_HIGH) ? high_eff : low_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_state  <= SQ_HIGH;
      phase_cnt <= 16'd0;
    end else begin
      sq_state  <= sq_state_nxt;
      phase_cnt <= phase_cnt_nxt;
    end
  end

  // ">=" lets a shortened time end the phase at once instead of wrapping the counter.
  always_comb begin
    sq_state_nxt  = sq_state;
    phase_cnt_nxt = phase_cnt;
    if (sq_start) begin
      sq_state_nxt  = SQ_HIGH;
      phase_cnt_nxt = 16'd0;
    end else if (mode == MODE_SQUARE) begin
      if (phase_cnt >= phase_limit - 16'd1) begin
        sq_state_nxt  = (sq_state == SQ_HIGH) ? SQ_LOW : SQ_HIGH;
        phase_cnt_nxt = 16'd0;
      end else begin
        phase_cnt_nxt = phase_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= pin_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef PIN_CTRL_EDGE_COUNT_EN
  logic        sync_prev;
  logic        rise;
  logic [15:0] edge_count;

  assign rise = sync_q && !sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev  <= 1'b0;
      edge_count <= 16'd0;
    end else begin
      sync_prev <= sync_q;
      if (wr_hit && (reg_sel == REG_EDGE_COUNT)) begin
        edge_count <= 16'd0;
      end else if ((mode == MODE_INPUT) && rise && (edge_count != 16'hFFFF)) begin
        edge_count <= edge_count + 16'd1;
      end
    end
  end

  assign edge_rd = edge_count;
`else
  assign edge_rd = 16'd0;
`endif

  // HIZ and INPUT both release the pin.
  always_comb begin
    pin_oe  = 1'b0;
    pin_out = 1'b0;
    case (mode)
      MODE_STATIC: begin
        pin_oe  = 1'b1;
        pin_out = static_val;
      end
      MODE_SQUARE: begin
        pin_oe  = 1'b1;
        pin_out = (sq_state == SQ_HIGH);
      end
      MODE_HIZ, MODE_INPUT: begin
        pin_oe  = 1'b0;
        pin_out = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = 16'd0;
    case (reg_sel)
      REG_MODE:       rd_mux = {14'd0, mode};
      REG_HIGH_TIME:  rd_mux = high_time;
      REG_LOW_TIME:   rd_mux = low_time;
      REG_STATIC_VAL: rd_mux = {15'd0, static_val};
      REG_EDGE_COUNT: rd_mux = edge_rd;
      REG_STATUS:     rd_mux = {13'd0, pin_oe, pin_out, sync_q};
      default:        rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rd_data  <= 16'd0;
      bus_rd_valid <= 1'b0;
    end else begin
      bus_rd_valid <= rd_hit;
      if (rd_hit) begin
        bus_rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_cmd_bus_pin_ctrl.sv
// tb/tb_cmd_bus_pin_ctrl.sv - self-checking bench for cmd_bus_pin_ctrl (vector table, directed sequences, random vs model)
module tb_cmd_bus_pin_ctrl;

  localparam logic [18:0] BASE = 19'h00100;
  localparam logic        RLVL = 1'b1;
`ifdef PIN_CTRL_EDGE_COUNT_EN
  localparam bit EC_EN = 1'b1;
`else
  localparam bit EC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [18:0] cmd_bus_addr;
  logic [15:0] cmd_bus_data;
  logic        cmd_bus_en;
  logic        cmd_bus_rd;
  logic        cmd_bus_wr;
  logic [15:0] bus_rd_data;
  logic        bus_rd_valid;
  logic        pin_in;
  logic        pin_out;
  logic        pin_oe;

  cmd_bus_pin_ctrl #(.BASE_ADDR(BASE), .RESET_LEVEL(RLVL)) dut (
    .clk(clk), .rst(rst),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_rd(cmd_bus_rd), .cmd_bus_wr(cmd_bus_wr),
    .bus_rd_data(bus_rd_data), .bus_rd_valid(bus_rd_valid),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_model = 1'b1;
  logic pin_drv = 1'b0;

  // Reference model: register values plus cycles elapsed since the waveform started.
  logic [1:0]  m_mode;
  logic [15:0] m_h, m_l, m_ec, m_data;
  logic        m_sv, m_valid;
  int          m_elapsed;
  bit          hist[$];

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_out();
    int hh, ll;
    hh = (m_h == 16'd0) ? 1 : int'(m_h);
    ll = (m_l == 16'd0) ? 1 : int'(m_l);
    case (m_mode)
      2'd0:    return m_sv;
      2'd1:    return (m_elapsed % (hh + ll)) < hh;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_oe();
    return m_mode <= 2'd1;
  endfunction

  function automatic logic [15:0] m_reg(input logic [3:0] r, input logic synced);
    case (r)
      4'd0:    return {14'd0, m_mode};
      4'd1:    return m_h;
      4'd2:    return m_l;
      4'd3:    return {15'd0, m_sv};
      4'd4:    return EC_EN ? m_ec : 16'd0;
      4'd5:    return {13'd0, m_oe(), m_out(), synced};
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_h = 16'd1; m_l = 16'd1; m_sv = RLVL; m_ec = 16'd0;
    m_elapsed = 0; m_valid = 1'b0; m_data = 16'd0;
    hist = {1'b0, 1'b0, 1'b0};
  endtask

  // hist holds pin_in as captured at past edges; the synced level lags two edges.
  task automatic model_step(input logic en, rd, wr, input logic [18:0] addr,
                            input logic [15:0] data, input logic pin);
    logic hit, synced, prevs, rising, restart;
    logic [1:0] mode_pre;
    logic [3:0] r;
    hit    = en && (addr[18:4] == BASE[18:4]);
    r      = addr[3:0];
    synced = hist[hist.size()-2];
    prevs  = hist[hist.size()-3];
    rising = synced && !prevs;
    mode_pre = m_mode;
    restart  = 1'b0;
    if (hit && rd && !wr) begin
      m_valid = 1'b1;
      m_data  = m_reg(r, synced);
    end else begin
      m_valid = 1'b0;
    end
    if (hit && wr) begin
      case (r)
        4'd0: begin m_mode = data[1:0]; restart = (data[1:0] == 2'd1); end
        4'd1: m_h  = data;
        4'd2: m_l  = data;
        4'd3: m_sv = data[0];
        default: ;
      endcase
    end
    if (EC_EN) begin
      if (hit && wr && r == 4'd4) m_ec = 16'd0;
      else if (mode_pre == 2'd3 && rising && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
    end
    if (restart) m_elapsed = 0;
    else if (mode_pre == 2'd1) m_elapsed++;
    hist.push_back(pin);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic bus_op(input logic en, rd, wr, input logic [18:0] addr, input logic [15:0] data);
    @(negedge clk);
    cmd_bus_en = en; cmd_bus_rd = rd; cmd_bus_wr = wr;
    cmd_bus_addr = addr; cmd_bus_data = data; pin_in = pin_drv;
    @(posedge clk);
    model_step(en, rd, wr, addr, data, pin_drv);
    #1;
    if (chk_model) begin
      check1("model_pin_out", pin_out, m_out());
      check1("model_pin_oe", pin_oe, m_oe());
      check1("model_rd_valid", bus_rd_valid, m_valid);
      if (m_valid) check16("model_rd_data", bus_rd_data, m_data);
    end
  endtask

  task automatic idle();
    bus_op(1'b0, 1'b0, 1'b0, BASE, 16'd0);
  endtask

  task automatic wr_reg(input logic [3:0] r, input logic [15:0] d);
    bus_op(1'b1, 1'b0, 1'b1, {BASE[18:4], r}, d);
  endtask

  task automatic rd_reg(input logic [3:0] r, output logic [15:0] d);
    bus_op(1'b1, 1'b1, 1'b0, {BASE[18:4], r}, 16'd0);
    check1("rd_valid_pulse", bus_rd_valid, 1'b1);
    d = bus_rd_data;
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic [18:0] a;
    logic [3:0]  r;
    logic        en, rd, wr, hit;

    tbl[0]  = '{4'd1,  16'hABCD, 16'hABCD};
    tbl[1]  = '{4'd2,  16'h1234, 16'h1234};
    tbl[2]  = '{4'd3,  16'hFFFF, 16'h0001};
    tbl[3]  = '{4'd0,  16'hFFF2, 16'h0002};
    tbl[4]  = '{4'd5,  16'h5555, 16'h0000};
    tbl[5]  = '{4'd0,  16'h0000, 16'h0000};
    tbl[6]  = '{4'd3,  16'h0000, 16'h0000};
    tbl[7]  = '{4'd5,  16'hFFFF, 16'h0004};
    tbl[8]  = '{4'd6,  16'h5555, 16'h0000};
    tbl[9]  = '{4'd15, 16'hFFFF, 16'h0000};
    tbl[10] = '{4'd4,  16'h1234, 16'h0000};
    tbl[11] = '{4'd1,  16'h0000, 16'h0000};

    rst = 1'b1; cmd_bus_en = 1'b0; cmd_bus_rd = 1'b0; cmd_bus_wr = 1'b0;
    cmd_bus_addr = 19'd0; cmd_bus_data = 16'd0; pin_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset_pin_out", pin_out, RLVL);
    check1("reset_pin_oe", pin_oe, 1'b1);
    check1("reset_rd_valid", bus_rd_valid, 1'b0);
    check16("reset_rd_data", bus_rd_data, 16'd0);
    rst = 1'b0;
    model_reset();

    rd_reg(4'd0, d);
    check16("reset_mode_read", d, 16'd0);
    idle();
    check1("rd_valid_one_cycle", bus_rd_valid, 1'b0);

    for (int i = 0; i < 12; i++) begin
      wr_reg(tbl[i].r, tbl[i].wdata);
      rd_reg(tbl[i].r, d);
      check16($sformatf("table_%0d", i), d, tbl[i].exp);
    end

    // Square wave H=3 L=2
    wr_reg(4'd1, 16'd3);
    wr_reg(4'd2, 16'd2);
    wr_reg(4'd0, 16'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) idle();
      check1($sformatf("sq32_%0d", i), pin_out, (i % 5) < 3);
      check1("sq_oe", pin_oe, 1'b1);
    end

    // Zero times act as one: toggle every cycle
    wr_reg(4'd0, 16'd0);
    wr_reg(4'd1, 16'd0);
    wr_reg(4'd2, 16'd0);
    wr_reg(4'd0, 16'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idle();
      check1($sformatf("sq00_%0d", i), pin_out, (i % 2) == 0);
    end

    // Restart while running
    wr_reg(4'd0, 16'd0);
    wr_reg(4'd1, 16'd2);
    wr_reg(4'd2, 16'd2);
    wr_reg(4'd0, 16'd1);
    idle(); idle();
    check1("restart_before", pin_out, 1'b0);
    wr_reg(4'd0, 16'd1);
    check1("restart_high0", pin_out, 1'b1);
    idle();
    check1("restart_high1", pin_out, 1'b1);
    idle();
    check1("restart_low", pin_out, 1'b0);

    // Shrinking HIGH_TIME below the running count ends the phase next cycle
    wr_reg(4'd0, 16'd0);
    wr_reg(4'd1, 16'd10);
    wr_reg(4'd2, 16'd2);
    chk_model = 1'b0;
    wr_reg(4'd0, 16'd1);
    repeat (6) idle();
    wr_reg(4'd1, 16'd3);
    for (int i = 0; i < 8; i++) begin
      logic e;
      e = (i == 0) || (i >= 3 && i <= 5);
      if (i > 0) idle();
      check1($sformatf("shrink_%0d", i), pin_out, e);
    end
    wr_reg(4'd0, 16'd0);
    chk_model = 1'b1;

    // INPUT mode edge counting
    wr_reg(4'd0, 16'd3);
    check1("input_oe", pin_oe, 1'b0);
    pin_drv = 1'b0;
    repeat (3) idle();
    for (int k = 0; k < 4; k++) begin
      pin_drv = 1'b1; repeat (3) idle();
      pin_drv = 1'b0; repeat (3) idle();
    end
    rd_reg(4'd4, d);
    check16("edge_count_4", d, EC_EN ? 16'd4 : 16'd0);
    pin_drv = 1'b1;
    idle(); idle();
    wr_reg(4'd4, 16'h00FF);
    pin_drv = 1'b0;
    repeat (3) idle();
    rd_reg(4'd4, d);
    check16("edge_clear_wins", d, 16'd0);
    pin_drv = 1'b1;
    idle(); idle();
    rd_reg(4'd5, d);
    check16("status_input_high", d, 16'h0001);
    rd_reg(4'd4, d);
    check16("edge_count_1", d, EC_EN ? 16'd1 : 16'd0);
    pin_drv = 1'b0;

    // Misses, disabled cycles and rd+wr collisions
    wr_reg(4'd0, 16'd0);
    bus_op(1'b1, 1'b0, 1'b1, BASE + 19'h10, 16'd2);
    check1("miss_wr_oe", pin_oe, 1'b1);
    bus_op(1'b1, 1'b1, 1'b0, BASE + 19'h10, 16'd0);
    check1("miss_rd_valid", bus_rd_valid, 1'b0);
    rd_reg(4'd0, d);
    check16("miss_mode_kept", d, 16'd0);
    bus_op(1'b0, 1'b0, 1'b1, {BASE[18:4], 4'd3}, 16'd1);
    rd_reg(4'd3, d);
    check16("en_low_ignored", d, 16'd0);
    bus_op(1'b1, 1'b1, 1'b1, {BASE[18:4], 4'd1}, 16'h0077);
    check1("rdwr_no_valid", bus_rd_valid, 1'b0);
    rd_reg(4'd1, d);
    check16("rdwr_write_applied", d, 16'h0077);

    // Asynchronous reset during the low phase, with a read response pending
    wr_reg(4'd1, 16'd1);
    wr_reg(4'd2, 16'd8);
    wr_reg(4'd0, 16'd1);
    idle();
    check1("pre_reset_low", pin_out, 1'b0);
    rd_reg(4'd1, d);
    @(negedge clk);
    cmd_bus_en = 1'b0; cmd_bus_rd = 1'b0; cmd_bus_wr = 1'b0;
    rst = 1'b1;
    #1;
    check1("async_rst_pin_out", pin_out, RLVL);
    check1("async_rst_oe", pin_oe, 1'b1);
    check1("async_rst_valid", bus_rd_valid, 1'b0);
    check16("async_rst_data", bus_rd_data, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_reg(4'd0, d); check16("post_rst_mode", d, 16'd0);
    rd_reg(4'd1, d); check16("post_rst_high", d, 16'd1);
    rd_reg(4'd2, d); check16("post_rst_low", d, 16'd1);
    rd_reg(4'd3, d); check16("post_rst_static", d, {15'd0, RLVL});

    // Reset asserted in the high phase of a running waveform
    wr_reg(4'd1, 16'd8);
    wr_reg(4'd0, 16'd1);
    idle();
    @(negedge clk);
    cmd_bus_en = 1'b0;
    rst = 1'b1;
    #1;
    check1("rst_high_pin_out", pin_out, RLVL);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_reg(4'd0, d); check16("rst_high_mode", d, 16'd0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      pin_drv = 1'($urandom_range(0, 1));
      en = ($urandom % 8) != 0;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 6);
      if ($urandom % 6 == 0) begin
        a = 19'($urandom);
        if (a[18:4] == BASE[18:4]) a[18:4] = a[18:4] ^ 15'h1;
      end else begin
        a = {BASE[18:4], r};
      end
      hit = en && (a[18:4] == BASE[18:4]);
      if (hit && wr && (a[3:0] == 4'd1 || a[3:0] == 4'd2) && m_mode == 2'd1) wr = 1'b0;
      if (a[3:0] == 4'd1 || a[3:0] == 4'd2) d = 16'($urandom_range(0, 4));
      else d = 16'($urandom);
      bus_op(en, rd, wr, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
